// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited instruction fetch front end with PC/word FIFO, redirect flush and stale-response drop
module instr_fetch #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            halt,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_instr,
   output logic            fetch_misalign
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = AW + 8;
   localparam logic [AW+1:0] DEPTH_L = (AW+2)'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
   typedef enum logic {RUN, MISALIGN} state_t;
   state_t state, state_nx;
   logic [XLEN-1:0] fetch_pc;
   logic [AW:0] outstanding, fcount;
   logic [DW-1:0] drop;
   logic [AW-1:0] pc_wr, pc_rd, fq_wr, fq_rd;
   logic [XLEN-1:0] pc_mem [FIFO_DEPTH];
   logic [XLEN-1:0] fq_pc [FIFO_DEPTH];
   logic [XLEN-1:0] fq_instr [FIFO_DEPTH];
   logic req_fire, rsp_drop, rsp_keep, pop;
   always_comb begin
      state_nx = redirect_valid ? (redirect_pc[1:0] != 2'b00 ? MISALIGN : RUN) : state;
      imem_req_valid = !rst && state == RUN && !halt && !redirect_valid &&
                       ({1'b0, outstanding} + {1'b0, fcount} < DEPTH_L);
      imem_req_addr = fetch_pc & ~XLEN'(3);
      dec_valid = !rst && state == RUN && !halt && fcount != '0;
      dec_pc = dec_valid ? fq_pc[fq_rd] : '0;
      dec_instr = dec_valid ? fq_instr[fq_rd] : NOP;
      fetch_misalign = state == MISALIGN;
      req_fire = imem_req_valid && imem_req_ready;
      rsp_drop = imem_rsp_valid && drop != '0;
      rsp_keep = imem_rsp_valid && drop == '0 && outstanding != '0;
      pop = dec_valid && dec_ready && !redirect_valid;
   end
   // A redirect turns every in-flight request into a pending discard
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         fetch_pc <= RESET_PC;
         outstanding <= '0;
         drop <= '0;
         fcount <= '0;
         pc_wr <= '0;
         pc_rd <= '0;
         fq_wr <= '0;
         fq_rd <= '0;
      end else begin
         state <= state_nx;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            outstanding <= '0;
            drop <= drop + DW'(outstanding) - DW'(rsp_drop || rsp_keep);
            fcount <= '0;
            pc_wr <= '0;
            pc_rd <= '0;
            fq_wr <= '0;
            fq_rd <= '0;
         end else begin
            fetch_pc <= req_fire ? fetch_pc + XLEN'(4) : fetch_pc;
            outstanding <= outstanding + (AW+1)'(req_fire) - (AW+1)'(rsp_keep);
            drop <= drop - DW'(rsp_drop);
            fcount <= fcount + (AW+1)'(rsp_keep) - (AW+1)'(pop);
            pc_wr <= pc_wr + AW'(req_fire);
            pc_rd <= pc_rd + AW'(rsp_keep);
            fq_wr <= fq_wr + AW'(rsp_keep);
            fq_rd <= fq_rd + AW'(pop);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (req_fire) pc_mem[pc_wr] <= imem_req_addr;
      if (rsp_keep && !redirect_valid) begin
         fq_pc[fq_wr] <= pc_mem[pc_rd];
         fq_instr[fq_wr] <= imem_rsp_data;
      end
   end
endmodule
